// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, total helpers and the
// display-stage bundle type carried through the sync/de delay line.
package vga_pkg;

  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 29;

  // Coordinates travel at this fixed width; the top zero-extends/truncates to WIDTH.
  localparam int unsigned MAX_WIDTH = 16;

  typedef logic [MAX_WIDTH-1:0] coord_t;

  typedef struct packed {
    logic   hs;
    logic   vs;
    logic   de;
    coord_t x;
    coord_t y;
    logic   ls;
    logic   fs;
  } vga_bundle_t;

  function automatic int unsigned h_total(int unsigned vis, int unsigned fp,
                                          int unsigned sync, int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(int unsigned vis, int unsigned fp,
                                          int unsigned sync, int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Output bundle of vga_timing_gen: fetch address plus delayed sync/de/coordinates.
// frame_cnt is present only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int unsigned WIDTH = 11
) ();

  logic [WIDTH-1:0] fetch_x;
  logic [WIDTH-1:0] fetch_y;
  logic             fetch_valid;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [WIDTH-1:0] xpos;
  logic [WIDTH-1:0] ypos;
  logic             line_start;
  logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  modport master (
    output fetch_x, fetch_y, fetch_valid, hsync, vsync, de, xpos, ypos,
           line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input fetch_x, fetch_y, fetch_valid, hsync, vsync, de, xpos, ypos,
          line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_sync_delay.sv
// LATENCY-stage, ce-gated shift register for the display bundle; async reset
// loads every stage with the inactive bundle so outputs go idle immediately.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter vga_bundle_t IDLE    = '0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        ce,
  input  vga_bundle_t d,
  output vga_bundle_t q
);

  vga_bundle_t stage_q [LATENCY];

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= IDLE;
      end
    end else if (ce) begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[LATENCY-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with early fetch address and a
// LATENCY-deep registered display stage. Optional frame counter: VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS   = DEF_H_VIS,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned V_VIS   = DEF_V_VIS,
  parameter int unsigned V_FP    = DEF_V_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned WIDTH   = 11
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic              ce,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = h_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [WIDTH-1:0] H_LAST = WIDTH'(H_TOTAL - 1);
  localparam logic [WIDTH-1:0] V_LAST = WIDTH'(V_TOTAL - 1);

  // One extra bit so a region ending exactly at 2^WIDTH still compares correctly.
  localparam logic [WIDTH:0] H_VIS_E    = (WIDTH+1)'(H_VIS);
  localparam logic [WIDTH:0] HS_START_E = (WIDTH+1)'(H_VIS + H_FP);
  localparam logic [WIDTH:0] HS_END_E   = (WIDTH+1)'(H_VIS + H_FP + H_SYNC);
  localparam logic [WIDTH:0] V_VIS_E    = (WIDTH+1)'(V_VIS);
  localparam logic [WIDTH:0] VS_START_E = (WIDTH+1)'(V_VIS + V_FP);
  localparam logic [WIDTH:0] VS_END_E   = (WIDTH+1)'(V_VIS + V_FP + V_SYNC);

  localparam vga_bundle_t IDLE = '{hs: !HS_POL, vs: !VS_POL, de: 1'b0, x: '0, y: '0,
                                   ls: 1'b0, fs: 1'b0};

  logic [WIDTH-1:0] h_cnt_q, h_cnt_d;
  logic [WIDTH-1:0] v_cnt_q, v_cnt_d;
  logic [WIDTH:0]   h_ext, v_ext;
  logic             h_vis, v_vis, vis;
  logic             hs_act, vs_act;
  vga_bundle_t      fetch_b, disp_b;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + WIDTH'(1);
      end else begin
        h_cnt_d = h_cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_ext  = {1'b0, h_cnt_q};
  assign v_ext  = {1'b0, v_cnt_q};
  assign h_vis  = h_ext < H_VIS_E;
  assign v_vis  = v_ext < V_VIS_E;
  assign vis    = h_vis && v_vis;
  assign hs_act = (h_ext >= HS_START_E) && (h_ext < HS_END_E);
  assign vs_act = (v_ext >= VS_START_E) && (v_ext < VS_END_E);

  always_comb begin
    fetch_b    = IDLE;
    fetch_b.hs = hs_act ? HS_POL : !HS_POL;
    fetch_b.vs = vs_act ? VS_POL : !VS_POL;
    fetch_b.de = vis;
    fetch_b.x  = vis ? coord_t'(h_cnt_q) : '0;
    fetch_b.y  = vis ? coord_t'(v_cnt_q) : '0;
    fetch_b.ls = (h_cnt_q == '0);
    fetch_b.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign vga.fetch_x     = h_cnt_q;
  assign vga.fetch_y     = v_cnt_q;
  assign vga.fetch_valid = vis && rst_n;

  vga_sync_delay #(
    .LATENCY (LATENCY),
    .IDLE    (IDLE)
  ) u_sync_delay (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .d         (fetch_b),
    .q         (disp_b)
  );

  assign vga.hsync       = disp_b.hs;
  assign vga.vsync       = disp_b.vs;
  assign vga.de          = disp_b.de;
  assign vga.xpos        = disp_b.x[WIDTH-1:0];
  assign vga.ypos        = disp_b.y[WIDTH-1:0];
  assign vga.line_start  = disp_b.ls;
  assign vga.frame_start = disp_b.fs;

  // Coordinates above WIDTH are always zero; fold them so they are not dangling.
  logic unused_coord_hi;
  assign unused_coord_hi = ^{disp_b.x, disp_b.y};

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (ce && disp_b.fs) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked against a raster model
// indexed by enabled-edge count. Also covers frame_cnt when VGA_TIMING_FRAME_CNT_EN is set.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst_n;
  logic ce;

  int unsigned k;
  int          total = 0;
  int          bad   = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen_if #(.WIDTH(11)) if0 ();
  vga_timing_gen_if #(.WIDTH(11)) if1 ();
  vga_timing_gen_if #(.WIDTH(11)) if2 ();

  vga_timing_gen u0 (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .vga       (if0)
  );

  vga_timing_gen #(
    .H_VIS(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(3)
  ) u1 (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .vga       (if1)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .LATENCY(4)
  ) u2 (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .vga       (if2)
  );

  logic [49:0] obs [3];
  assign obs[0] = {if0.fetch_x, if0.fetch_y, if0.fetch_valid, if0.hsync, if0.vsync, if0.de,
                   if0.xpos, if0.ypos, if0.line_start, if0.frame_start};
  assign obs[1] = {if1.fetch_x, if1.fetch_y, if1.fetch_valid, if1.hsync, if1.vsync, if1.de,
                   if1.xpos, if1.ypos, if1.line_start, if1.frame_start};
  assign obs[2] = {if2.fetch_x, if2.fetch_y, if2.fetch_valid, if2.hsync, if2.vsync, if2.de,
                   if2.xpos, if2.ypos, if2.line_start, if2.frame_start};

  // Raster model: after kk enabled edges the fetch is at raster index kk and the
  // display shows raster index kk-lat (idle before that).
  function automatic logic [49:0] model(int unsigned kk, bit rl,
                                        int unsigned hv, int unsigned hfp, int unsigned hsw,
                                        int unsigned hbp, int unsigned vv, int unsigned vfp,
                                        int unsigned vsw, int unsigned vbp,
                                        bit hpol, bit vpol, int unsigned lat);
    int unsigned ht, vt, fx, fy, px, py, x, y;
    bit fv, hs, vs, de, ls, fs;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    fx = kk % ht;
    fy = (kk / ht) % vt;
    fv = !rl && (fx < hv) && (fy < vv);
    hs = !hpol; vs = !vpol; de = 0; x = 0; y = 0; ls = 0; fs = 0;
    if (!rl && kk >= lat) begin
      px = (kk - lat) % ht;
      py = ((kk - lat) / ht) % vt;
      hs = (px >= hv + hfp && px < hv + hfp + hsw) ? hpol : !hpol;
      vs = (py >= vv + vfp && py < vv + vfp + vsw) ? vpol : !vpol;
      de = (px < hv) && (py < vv);
      x  = de ? px : 0;
      y  = de ? py : 0;
      ls = (px == 0);
      fs = (px == 0) && (py == 0);
    end
    return {fx[10:0], fy[10:0], fv, hs, vs, de, x[10:0], y[10:0], ls, fs};
  endfunction

  function automatic logic [49:0] model_dut(int d, int unsigned kk, bit rl);
    case (d)
      0:       return model(kk, rl, 640, 16, 96, 48, 480, 10, 2, 29, 1'b0, 1'b0, 2);
      1:       return model(kk, rl, 800, 40, 128, 88, 480, 10, 2, 29, 1'b1, 1'b1, 3);
      default: return model(kk, rl, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b1, 4);
    endcase
  endfunction

  // u2 has LATENCY 4 and a 120-pixel frame; count display frame_starts already passed.
  function automatic logic [15:0] fc_model(int unsigned kk);
    if (kk > 4) return 16'((kk - 5) / 120 + 1);
    return 16'd0;
  endfunction

  task automatic step(input bit ce_v);
    ce = ce_v;
    @(posedge pixel_clk);
    if (ce_v && rst_n) k++;
    #1;
  endtask

  task automatic test_reset();
    logic [49:0] exp_v;
    rst_n = 1'b0;
    k     = 0;
    for (int n = 0; n < 4; n++) begin
      step(1'b1);
      for (int d = 0; d < 3; d++) begin
        exp_v = model_dut(d, k, 1'b1);
        total++;
        if (obs[d] !== exp_v) begin
          bad++;
          $display("FAIL reset dut%0d got=%h want=%h", d, obs[d], exp_v);
        end
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      total++;
      if (if2.frame_cnt !== 16'd0) begin
        bad++;
        $display("FAIL reset frame_cnt got=%0d want=0", if2.frame_cnt);
      end
`endif
    end
  endtask

  task automatic test_run(input int cycles);
    logic [49:0] exp_v;
    #3 rst_n = 1'b1;
    for (int n = 0; n < cycles; n++) begin
      step(1'b1);
      for (int d = 0; d < 3; d++) begin
        exp_v = model_dut(d, k, !rst_n);
        total++;
        if (obs[d] !== exp_v) begin
          bad++;
          $display("FAIL run dut%0d k=%0d got=%h want=%h", d, k, obs[d], exp_v);
        end
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      total++;
      if (if2.frame_cnt !== fc_model(k)) begin
        bad++;
        $display("FAIL run frame_cnt k=%0d got=%0d want=%0d", k, if2.frame_cnt, fc_model(k));
      end
`endif
    end
  endtask

  task automatic test_sync_width();
    int n, cnt;
    // u0: hsync falls 656 clocks after line_start and stays low 96 clocks.
    n = 0;
    while (if0.line_start !== 1'b1 && n < 2000) begin step(1'b1); n++; end
    cnt = 0;
    while (if0.hsync !== 1'b0 && n < 4000) begin step(1'b1); cnt++; n++; end
    total++;
    if (cnt != 656) begin
      bad++;
      $display("FAIL hs_offset got=%0d want=656", cnt);
    end
    cnt = 0;
    while (if0.hsync === 1'b0 && n < 4000) begin step(1'b1); cnt++; n++; end
    total++;
    if (cnt != 96) begin
      bad++;
      $display("FAIL hs_width0 got=%0d want=96", cnt);
    end
    // u1: line period 1056, hsync high 128.
    n = 0;
    while (if1.line_start !== 1'b1 && n < 2000) begin step(1'b1); n++; end
    cnt = 0;
    do begin step(1'b1); cnt++; n++; end while (if1.line_start !== 1'b1 && n < 4000);
    total++;
    if (cnt != 1056) begin
      bad++;
      $display("FAIL line_period1 got=%0d want=1056", cnt);
    end
    while (if1.hsync !== 1'b1 && n < 6000) begin step(1'b1); n++; end
    cnt = 0;
    while (if1.hsync === 1'b1 && n < 6000) begin step(1'b1); cnt++; n++; end
    total++;
    if (cnt != 128) begin
      bad++;
      $display("FAIL hs_width1 got=%0d want=128", cnt);
    end
  endtask

  task automatic test_ce_toggle(input int cycles);
    logic [49:0] exp_v;
    bit          ce_v;
    for (int n = 0; n < cycles; n++) begin
      if (n < 800) ce_v = (n % 4 == 0) || (n % 4 == 3);
      else         ce_v = 1'($urandom_range(0, 1));
      step(ce_v);
      for (int d = 0; d < 3; d++) begin
        exp_v = model_dut(d, k, !rst_n);
        total++;
        if (obs[d] !== exp_v) begin
          bad++;
          $display("FAIL ce dut%0d k=%0d ce=%0b got=%h want=%h", d, k, ce_v, obs[d], exp_v);
        end
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      total++;
      if (if2.frame_cnt !== fc_model(k)) begin
        bad++;
        $display("FAIL ce frame_cnt k=%0d got=%0d want=%0d", k, if2.frame_cnt, fc_model(k));
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [49:0] exp_v;
    int          n;
    n = 0;
    while (!(k % 800 == 300 && k >= 800) && n < 3000) begin step(1'b1); n++; end
    total++;
    if (k % 800 != 300) begin
      bad++;
      $display("FAIL mid_reach got=%0d want=300", k % 800);
    end
    #2 rst_n = 1'b0;
    k = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_v = model_dut(d, 0, 1'b1);
      total++;
      if (obs[d] !== exp_v) begin
        bad++;
        $display("FAIL mid_async dut%0d got=%h want=%h", d, obs[d], exp_v);
      end
    end
    step(1'b1);
    step(1'b1);
    test_run(1300);
  endtask

  initial begin
    ce = 1'b0;
    k  = 0;
    test_reset();
    test_run(3000);
    test_sync_width();
    test_ce_toggle(2500);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator; successor to the fixed 640x480 controller. Drives hsync/vsync/de and pixel coordinates to the video DAC pins. Also issues an early fetch address so frame-buffer or detection-overlay memory with LATENCY cycles of read delay lines up with the delayed sync/de outputs. It sits between the pixel clock domain and the frame buffer or overlay mixer.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 29, vertical back porch
- HS_POL / VS_POL, 0 / 0, active sync level (0 = active-low)
- LATENCY, 2, fetch-to-display delay in enabled cycles, legal 1..8
- WIDTH, 11, counter/coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^WIDTH
- pixel_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  pixel clock enable; 0 freezes counters and pipeline
- fetch_x, fetch_y  out  WIDTH  memory read address, valid when fetch_valid
- fetch_valid  out  1  fetch coordinate is inside the visible area
- hsync, vsync  out  1  sync outputs, polarity per HS_POL/VS_POL
- de  out  1  display enable, aligned with memory data
- xpos, ypos  out  WIDTH  coordinate of the pixel currently shown; 0 when de=0
- line_start, frame_start  out  1  one-cycle pulses aligned with display stage

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (521).
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, and itself wraps after V_TOTAL-1.
- Region order per line/frame: visible, front porch, sync, back porch.
  - hsync is active for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC).
  - vsync is active for v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC), whole lines.
- Fetch stage is combinational from the counters:
  - fetch_x = h_cnt, fetch_y = v_cnt.
  - fetch_valid = (h_cnt<H_VIS) && (v_cnt<V_VIS) && rst_n.
- Display stage: a LATENCY-deep register pipeline of {hs, vs, de, x, y, line_start, frame_start}, advanced only when ce=1.
- line_start = (h_cnt==0); frame_start = (h_cnt==0 && v_cnt==0).
- xpos/ypos are forced to 0 whenever de=0.
- All arithmetic is unsigned WIDTH bits. Region boundaries are elaboration-time constants; no runtime subtraction.

## Timing
- Reset values:
  - h_cnt=v_cnt=0.
  - All pipeline stages inactive: hsync=~HS_POL? no — hsync=!HS_POL, vsync=!VS_POL (inactive levels).
  - de=0, xpos=ypos=0, pulses=0.
- fetch_valid is held at 0 while rst_n is asserted.
- First enabled edge after reset release shows pixel (0,0) at fetch. de/xpos=0/ypos=0 follow exactly LATENCY enabled edges later.
- Sync and de outputs are always registered (glitch-free). The delay counts enabled edges, not clock edges.
- ce=0: all outputs hold their values; counters do not advance.
- End of frame: h_cnt=H_TOTAL-1 with v_cnt=V_TOTAL-1 wraps both counters to 0 on the same edge.
- Reset mid-frame: asynchronous clear of counters and pipeline; display outputs go inactive immediately.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - Adds output frame_cnt [15:0], reset 0.
  - Increments on each display-stage frame_start; wraps 0xFFFF→0.
  - Held when ce=0.
- Undefined: frame_cnt port and logic are absent; all other behaviour is identical.

## Structure
- Shared package vga_pkg holds:
  - Default 640x480@60 timing constants.
  - Derived H_TOTAL/V_TOTAL functions.
  - Typedef for the display-stage bundle {hs, vs, de, x, y, ls, fs}.
- Sub-module vga_sync_delay: parametrised LATENCY-stage, ce-gated shift register for the bundle, with asynchronous reset to inactive values.

## Test plan
- Reset release with defaults, ce=1 → 800 clocks per line, 521 lines per frame.
  - hsync low for exactly 96 clocks starting 656 clocks after line_start.
- LATENCY=3:
  - fetch (0,0) → de=1 with xpos=0, ypos=0 three edges later.
  - fetch (639,479) → last de=1 three edges later.
- ce toggling 1,0,0,1 → counters and outputs frozen during the 0 cycles; hsync width still 96 enabled cycles.
- rst_n asserted at h_cnt=300, v_cnt=200 → outputs immediately inactive.
  - After release, frame restarts at (0,0) with frame_start after LATENCY edges.
- HS_POL=1, VS_POL=1, H_VIS=800, H_FP=40, H_SYNC=128, H_BP=88 (H_TOTAL 1056) → hsync high for 128 clocks; line period 1056.
- VGA_TIMING_FRAME_CNT_EN defined, run 3 frames from reset → frame_cnt reads 1, 2, 3 after each display-stage frame_start.
